seg_scan_bcd: RTL

- Parametrised successor to the fixed 8-digit seven-segment scanner.
- Accepts a binary value over a valid/ready handshake and converts it to BCD sequentially with a double-dabble FSM.
- Drives a time-multiplexed display of NUM_DIGITS digits with leading-zero blanking, per-digit raw-character override, overflow indication and configurable segment/anode polarity.
- Sits between the calculator datapath (results, cycle counts, countdowns) and the board display pins.

---
 rtl/seg_scan_bcd.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_bcd.sv
// Multiplexed seven-segment scanner with a sequential double-dabble binary-to-BCD converter.
// Optional blinking digits are built only when SEG_BLINK_EN is defined.
module seg_scan_bcd #(
  parameter int NUM_DIGITS     = 8,
  parameter int VAL_WIDTH      = 32,
  parameter int SCAN_DIV       = 65536,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLINK_DIV      = 25000000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    val_valid,
  output logic                    val_ready,
  input  logic [VAL_WIDTH-1:0]    val_data,
  input  logic                    lz_blank,
  input  logic [NUM_DIGITS-1:0]   raw_mask,
  input  logic [8*NUM_DIGITS-1:0] raw_chars,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [7:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   seg_an,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic                    overflow
);

  localparam int BW  = 4*NUM_DIGITS;
  localparam int KW  = $clog2(VAL_WIDTH+1);
  localparam int SCW = $clog2(SCAN_DIV);
  localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0]            SEG_BLANK = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] AN_IDLE   = (AN_ACTIVE_LOW != 0) ? '1 : '0;

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t              r_state, w_next;
  logic [VAL_WIDTH-1:0] r_bin;
  logic [BW-1:0]       r_bcd, w_adj;
  logic                r_sticky;
  logic [KW-1:0]       r_bits;
  logic                w_load, w_shift, w_commit;

  logic [SCW-1:0]      r_scan_cnt;
  logic [IW-1:0]       r_idx;
  logic [NUM_DIGITS-1:0]      w_lz, w_blink_hide, w_onehot;
  logic [NUM_DIGITS-1:0][7:0] w_codes;
  logic [7:0]          w_cur_code;

  function automatic logic [7:0] glyph(input logic [3:0] d);
    case (d)
      4'd0: glyph = 8'hC0;
      4'd1: glyph = 8'hF9;
      4'd2: glyph = 8'hA4;
      4'd3: glyph = 8'hB0;
      4'd4: glyph = 8'h99;
      4'd5: glyph = 8'h92;
      4'd6: glyph = 8'h82;
      4'd7: glyph = 8'hF8;
      4'd8: glyph = 8'h80;
      4'd9: glyph = 8'h90;
      default: glyph = 8'hFF;
    endcase
  endfunction

  // Converter FSM
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (val_valid) w_next = S_SHIFT;
      S_SHIFT:  if (r_bits == KW'(VAL_WIDTH-1)) w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    val_ready = (r_state == S_IDLE);
    w_load    = (r_state == S_IDLE) && val_valid;
    w_shift   = (r_state == S_SHIFT);
    w_commit  = (r_state == S_COMMIT);
  end

  always_comb begin
    w_adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      w_adj[4*i +: 4] = (r_bcd[4*i +: 4] >= 4'd5) ? r_bcd[4*i +: 4] + 4'd3 : r_bcd[4*i +: 4];
  end

  // Bit leaving the top adjusted digit means the value needs more digits than we have.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_sticky <= 1'b0;
      r_bits   <= '0;
      bcd_out  <= '0;
      overflow <= 1'b0;
    end else begin
      if (w_load) begin
        r_bin    <= val_data;
        r_bcd    <= '0;
        r_sticky <= 1'b0;
        r_bits   <= '0;
      end
      if (w_shift) begin
        r_bcd    <= {w_adj[BW-2:0], r_bin[VAL_WIDTH-1]};
        r_bin    <= r_bin << 1;
        r_sticky <= r_sticky | w_adj[BW-1];
        r_bits   <= r_bits + 1'b1;
      end
      if (w_commit) begin
        bcd_out  <= r_bcd;
        overflow <= r_sticky;
      end
    end
  end

  // Digit scan
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (r_scan_cnt == SCW'(SCAN_DIV-1)) begin
      r_scan_cnt <= '0;
      r_idx      <= (r_idx == IW'(NUM_DIGITS-1)) ? '0 : r_idx + 1'b1;
    end else begin
      r_scan_cnt <= r_scan_cnt + 1'b1;
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BKW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BKW-1:0] r_blink_cnt;
  logic           r_blink_phase;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (r_blink_cnt == BKW'(BLINK_DIV-1)) begin
      r_blink_cnt   <= '0;
      r_blink_phase <= ~r_blink_phase;
    end else begin
      r_blink_cnt   <= r_blink_cnt + 1'b1;
    end
  end

  assign w_blink_hide = r_blink_phase ? blink_mask : '0;
`else
  logic w_unused_blink;
  assign w_unused_blink = (^blink_mask) | (BLINK_DIV == 0);
  assign w_blink_hide   = '0;
`endif

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    logic v_hz;
    w_lz = '0;
    v_hz = 1'b1;
    for (int i = NUM_DIGITS-1; i >= 0; i--) begin
      v_hz    = v_hz & (bcd_out[4*i +: 4] == 4'd0);
      w_lz[i] = v_hz & lz_blank & (i != 0);
    end
  end

  always_comb begin
    w_codes = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (raw_mask[i])          w_codes[i] = raw_chars[8*i +: 8];
      else if (w_blink_hide[i]) w_codes[i] = 8'hFF;
      else if (overflow)        w_codes[i] = 8'hBF;
      else if (w_lz[i])         w_codes[i] = 8'hFF;
      else                      w_codes[i] = glyph(bcd_out[4*i +: 4]);
    end
  end

  always_comb begin
    w_cur_code = 8'hFF;
    w_onehot   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_cur_code  = w_codes[i];
        w_onehot[i] = 1'b1;
      end
    end
  end

  // Anode and segments come from the same index on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_out <= SEG_BLANK;
      seg_an  <= AN_IDLE;
    end else begin
      seg_out <= (SEG_ACTIVE_LOW != 0) ? w_cur_code : ~w_cur_code;
      seg_an  <= (AN_ACTIVE_LOW != 0) ? ~w_onehot : w_onehot;
    end
  end

endmodule
